seq_detect_scheduler: RTL and testbench

//  Shares one serial pattern-match engine among NUM_CH bit-serial channels.

---
 rtl/seq_detect_scheduler_pkg.sv | 13 +
 rtl/seq_detect_scheduler_if.sv | 28 ++
 rtl/seq_detect_scheduler_rr_arbiter.sv | 30 +++
 rtl/seq_detect_scheduler.sv | 86 ++++++++
 tb/tb_seq_detect_scheduler.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_scheduler_pkg.sv
// seq_sched_pkg: default pattern constants and channel-index width helper
package seq_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_PAT_LEN = 4;
    localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
    localparam int DEF_CNT_W = 8;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// seq_detect_scheduler_if: channel handshake, match event and counter read bus
interface seq_detect_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 8
);
    localparam int CH_W = seq_sched_pkg::ch_w(NUM_CH);

    logic en;
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_bit;
    logic [NUM_CH-1:0] ch_clear;
    logic [NUM_CH-1:0] ch_ready;
    logic match_valid;
    logic [CH_W-1:0] match_ch;
    logic [CH_W-1:0] rd_ch;
    logic [CNT_W-1:0] rd_count;

    modport master (
        output en, ch_valid, ch_bit, ch_clear, rd_ch,
        input ch_ready, match_valid, match_ch, rd_count
    );

    modport slave (
        input en, ch_valid, ch_bit, ch_clear, rd_ch,
        output ch_ready, match_valid, match_ch, rd_count
    );

endinterface

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting the search at ptr
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic granted
);

    int j;

    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        granted = 1'b0;
        j = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!granted && req[j]) begin
                granted = 1'b1;
                gnt[j] = 1'b1;
                gnt_idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: one pattern-match engine time-shared across serial channels
module seq_detect_scheduler
    import seq_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic reset,
    seq_detect_scheduler_if.slave bus
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] gnt_idx;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic granted;
    logic [PAT_LEN-1:0] win [NUM_CH];
    logic [FILL_W-1:0] fill [NUM_CH];
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [PAT_LEN-1:0] new_win;
    logic [FILL_W-1:0] new_fill;
    logic hit;
    logic mv_q;
    logic [CH_W-1:0] mch_q;

    // a clearing channel is never granted, so its context write cannot collide with the engine
    assign req = bus.ch_valid & ~bus.ch_clear & {NUM_CH{bus.en & ~reset}};

    rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
        .req(req),
        .ptr(ptr),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .granted(granted)
    );

    assign bus.ch_ready = gnt;
    assign bus.match_valid = mv_q;
    assign bus.match_ch = mch_q;
    assign bus.rd_count = (int'(bus.rd_ch) < NUM_CH) ? cnt[bus.rd_ch] : '0;

    always_comb begin
        new_win = {win[gnt_idx][PAT_LEN-2:0], bus.ch_bit[gnt_idx]};
        new_fill = (fill[gnt_idx] == FULL) ? FULL : fill[gnt_idx] + 1'b1;
        hit = granted && (new_win == PATTERN) && (new_fill == FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            mv_q <= 1'b0;
            mch_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                win[i] <= '0;
                fill[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            mv_q <= hit;
            if (granted) begin
                ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
                mch_q <= gnt_idx;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.ch_clear[i]) begin
                    win[i] <= '0;
                    fill[i] <= '0;
                    cnt[i] <= '0;
                end else if (gnt[i]) begin
                    win[i] <= new_win;
                    fill[i] <= new_fill;
                    if (hit && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb_seq_detect_scheduler: directed checks of arbitration, matching, clear, saturation and reset
module tb_seq_detect_scheduler;

    localparam int NUM_CH = 4;

    logic clk = 1'b0;
    logic reset;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] mvs;

    seq_detect_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(8)) bus ();
    seq_detect_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(2)) bus2 ();

    assign bus2.en = bus.en;
    assign bus2.ch_valid = bus.ch_valid;
    assign bus2.ch_bit = bus.ch_bit;
    assign bus2.ch_clear = bus.ch_clear;
    assign bus2.rd_ch = bus.rd_ch;

    seq_detect_scheduler #(.NUM_CH(NUM_CH), .CNT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    seq_detect_scheduler #(.NUM_CH(NUM_CH), .CNT_W(2)) dut_sat (
        .clk(clk),
        .reset(reset),
        .bus(bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int c, input logic b, output logic mv);
        @(negedge clk);
        bus.ch_valid = 4'b0001 << c;
        bus.ch_bit[c] = b;
        @(posedge clk);
        #1;
        mv = bus.match_valid;
        bus.ch_valid = '0;
    endtask

    task automatic send_bits(input int c, input logic [31:0] bits, input int n, output logic [31:0] mv_seq);
        logic mv;
        mv_seq = '0;
        for (int i = 0; i < n; i++) begin
            send(c, bits[n-1-i], mv);
            mv_seq = {mv_seq[30:0], mv};
        end
    endtask

    task automatic read_count(input int c, input logic [31:0] exp, input string tag);
        bus.rd_ch = 2'(c);
        #1;
        check(tag, 32'(bus.rd_count), exp);
    endtask

    task automatic clear_mask(input logic [NUM_CH-1:0] m);
        @(negedge clk);
        bus.ch_clear = m;
        @(negedge clk);
        bus.ch_clear = '0;
    endtask

    initial begin
        reset = 1'b1;
        bus.en = 1'b1;
        bus.ch_valid = '1;
        bus.ch_bit = '0;
        bus.ch_clear = '0;
        bus.rd_ch = '0;
        #3;
        check("reset_ready", 32'(bus.ch_ready), 32'h0);
        check("reset_mv", 32'(bus.match_valid), 32'h0);
        check("reset_mch", 32'(bus.match_ch), 32'h0);
        check("reset_cnt", 32'(bus.rd_count), 32'h0);
        @(negedge clk);
        bus.ch_valid = '0;
        @(negedge clk);
        reset = 1'b0;

        send_bits(0, 32'b1011, 4, mvs);
        check("t1_mv", mvs, 32'h1);
        check("t1_mch", 32'(bus.match_ch), 32'h0);
        read_count(0, 32'd1, "t1_cnt");
        @(posedge clk);
        #1;
        check("t1_pulse_end", 32'(bus.match_valid), 32'h0);

        clear_mask(4'b0001);
        read_count(0, 32'd0, "t2_cleared");
        send_bits(0, 32'b1011011, 7, mvs);
        check("t2_overlap", mvs, 32'h09);
        read_count(0, 32'd2, "t2_cnt");

        @(negedge clk);
        bus.ch_valid = 4'b0001;
        bus.ch_clear = 4'b0001;
        #1;
        check("t5_clear_ready", 32'(bus.ch_ready), 32'h0);
        @(negedge clk);
        bus.ch_valid = '0;
        bus.ch_clear = '0;
        read_count(0, 32'd0, "t5_cnt_zero");
        send_bits(0, 32'b011, 3, mvs);
        check("t5_fresh", mvs, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.ch_valid = '1;
        bus.ch_bit = 4'b0101;
        for (int k = 0; k < NUM_CH; k++) begin
            #1;
            check($sformatf("t3_rr%0d", k), 32'(bus.ch_ready), 32'h1 << k);
            @(negedge clk);
        end
        bus.ch_valid = '0;
        check("t3_no_mv", 32'(bus.match_valid), 32'h0);
        send_bits(2, 32'b011, 3, mvs);
        check("t3_ch2_one_bit", mvs, 32'h1);
        check("t3_mch", 32'(bus.match_ch), 32'h2);

        clear_mask('1);
        mvs = '0;
        begin
            logic mv;
            send(1, 1'b1, mv); mvs = {mvs[30:0], mv};
            send(1, 1'b0, mv); mvs = {mvs[30:0], mv};
            send(2, 1'b1, mv); mvs = {mvs[30:0], mv};
            send(1, 1'b1, mv); mvs = {mvs[30:0], mv};
            send(1, 1'b1, mv); mvs = {mvs[30:0], mv};
        end
        check("t4_mv", mvs, 32'h01);
        check("t4_mch", 32'(bus.match_ch), 32'h1);
        send_bits(2, 32'b011, 3, mvs);
        check("t4_ch2_kept", mvs, 32'h1);
        check("t4_mch2", 32'(bus.match_ch), 32'h2);
        read_count(1, 32'd1, "t4_cnt1");
        read_count(2, 32'd1, "t4_cnt2");
        read_count(3, 32'd0, "t4_cnt3");

        @(negedge clk);
        bus.ch_valid = 4'b0011;
        #1;
        check("wrap_grant", 32'(bus.ch_ready), 32'h1);
        bus.ch_valid = '1;
        bus.en = 1'b0;
        #1;
        check("en_low", 32'(bus.ch_ready), 32'h0);
        bus.ch_valid = '0;
        bus.en = 1'b1;

        @(negedge clk);
        bus.ch_valid = 4'b0010;
        bus.ch_clear = 4'b0010;
        #1;
        check("clr1_ready", 32'(bus.ch_ready), 32'h0);
        @(negedge clk);
        bus.ch_valid = '0;
        bus.ch_clear = '0;
        read_count(1, 32'd0, "clr1_cnt1");
        read_count(2, 32'd1, "clr1_cnt2_kept");
        check("mch_hold", 32'(bus.match_ch), 32'h2);
        check("mv_idle", 32'(bus.match_valid), 32'h0);

        clear_mask('1);
        send_bits(0, 32'b1011011011011011, 16, mvs);
        check("t6_mv", mvs, 32'h1249);
        read_count(0, 32'd5, "t6_cnt_wide");
        check("t6_cnt_sat", 32'(bus2.rd_count), 32'd3);
        reset = 1'b1;
        #1;
        check("t6_rst_mv", 32'(bus.match_valid), 32'h0);
        check("t6_rst_mv_sat", 32'(bus2.match_valid), 32'h0);
        check("t6_rst_cnt", 32'(bus.rd_count), 32'h0);
        check("t6_rst_cnt_sat", 32'(bus2.rd_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
